// File: rtl/uart_tx_multi_pop.sv
// UART transmitter that drains a multi-pop byte FIFO in bursts of up to NO
// bytes and sends them as back-to-back start/data/stop frames on tx.
module uart_tx_multi_pop #(
   parameter int unsigned W       = 8,
   parameter int unsigned NO      = 4,
   parameter int unsigned WN      = $clog2(NO + 1),
   parameter int unsigned CLK_DIV = 434
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [WN-1:0]   can_pop,
   input  logic [NO*W-1:0] pop_data,
   output logic [WN-1:0]   pop,
   output logic            tx,
   output logic            busy,
   output logic [15:0]     frames_sent
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
   localparam int unsigned IW = (NO > 1) ? $clog2(NO) : 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] div, div_nxt;
   logic [BW-1:0] bit_idx, bit_idx_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic [WN-1:0] left, left_nxt;
   logic [15:0]   frames_nxt;
   logic          tx_nxt;
   logic          bit_end;
   logic [W-1:0]  burst_buf [NO];

   // Pop request: only from IDLE, clamped to the burst buffer depth.
   always_comb begin
      pop = '0;
      if (state == IDLE && can_pop != '0) begin
         pop = (can_pop > WN'(NO)) ? WN'(NO) : can_pop;
      end
   end

   // Busy whenever a burst is in flight.
   always_comb begin
      busy = (state != IDLE);
   end

   // Next-state logic; tx is precomputed from the state being entered so the
   // line can come straight from a register with no extra cycle of latency.
   always_comb begin
      state_nxt   = state;
      div_nxt     = div;
      bit_idx_nxt = bit_idx;
      idx_nxt     = idx;
      left_nxt    = left;
      frames_nxt  = frames_sent;
      tx_nxt      = 1'b1;
      bit_end     = (div == DW'(CLK_DIV - 1));

      if (state != IDLE) begin
         div_nxt = bit_end ? '0 : div + DW'(1);
      end

      case (state)
         IDLE: begin
            if (pop != '0) begin
               state_nxt = START;
               div_nxt   = '0;
               left_nxt  = pop;
               idx_nxt   = '0;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt   = DATA;
               bit_idx_nxt = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == BW'(W - 1)) begin
                  state_nxt = STOP;
               end else begin
                  bit_idx_nxt = bit_idx + BW'(1);
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               frames_nxt = frames_sent + 16'd1;
               left_nxt   = left - WN'(1);
               if (left != WN'(1)) begin
                  idx_nxt   = idx + IW'(1);
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = burst_buf[idx_nxt][bit_idx_nxt];
         default: tx_nxt = 1'b1;
      endcase
   end

   // State, counters and the registered serial line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         div         <= '0;
         bit_idx     <= '0;
         idx         <= '0;
         left        <= '0;
         frames_sent <= '0;
         tx          <= 1'b1;
      end else begin
         state       <= state_nxt;
         div         <= div_nxt;
         bit_idx     <= bit_idx_nxt;
         idx         <= idx_nxt;
         left        <= left_nxt;
         frames_sent <= frames_nxt;
         tx          <= tx_nxt;
      end
   end

   // Burst buffer: captures the popped FIFO head words on the pop edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NO; i++) begin
            burst_buf[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NO; i++) begin
            if (i < 32'(pop)) begin
               burst_buf[i] <= pop_data[i*W +: W];
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_multi_pop.sv
// Directed bench for uart_tx_multi_pop with a queue-backed FIFO and a tx decoder.
module tb_uart_tx_multi_pop;

   localparam int DIV = 4;
   localparam int NB  = 4;

   logic        clk;
   logic        rst;
   logic [2:0]  can_pop;
   logic [31:0] pop_data;
   logic [2:0]  pop;
   logic        tx;
   logic        busy;
   logic [15:0] frames_sent;

   int checks = 0;
   int errors = 0;

   logic [7:0] fifo [$];
   logic [7:0] exp_q [$];
   logic [7:0] rx_q [$];
   int         pop_log [$];
   int         pop_at [$];

   logic        s_tx, s_busy;
   logic [2:0]  s_pop;
   logic [15:0] s_frames;
   int          ncyc = 0;
   int          viol = 0;
   int          frame_err = 0;
   int          dec_cnt = -1;
   logic [9:0]  dec_bits;
   logic [63:0] wave = '0;

   uart_tx_multi_pop #(
      .W(8),
      .NO(NB),
      .WN(3),
      .CLK_DIV(DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .can_pop(can_pop),
      .pop_data(pop_data),
      .pop(pop),
      .tx(tx),
      .busy(busy),
      .frames_sent(frames_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_fifo();
      int n;
      n = (fifo.size() > 7) ? 7 : fifo.size();
      can_pop  = 3'(n);
      pop_data = '0;
      for (int i = 0; i < NB && i < fifo.size(); i++) pop_data[i*8 +: 8] = fifo[i];
   endtask

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      exp_q.push_back(b);
      drive_fifo();
   endtask

   // One clock: sample at negedge, decode tx, then apply FIFO removal after the edge.
   task automatic cycle();
      @(negedge clk);
      s_tx     = tx;
      s_busy   = busy;
      s_pop    = pop;
      s_frames = frames_sent;
      ncyc++;
      if (s_pop != 3'd0) begin
         pop_log.push_back(int'(s_pop));
         pop_at.push_back(ncyc);
         if (s_busy) viol++;
      end
      wave = {wave[62:0], s_tx};
      if (dec_cnt < 0 && s_tx == 1'b0) dec_cnt = 0;
      if (dec_cnt >= 0) begin
         if (dec_cnt % DIV == DIV / 2) dec_bits[dec_cnt / DIV] = s_tx;
         if (dec_cnt == 10 * DIV - 1) begin
            if (dec_bits[0] !== 1'b0 || dec_bits[9] !== 1'b1) frame_err++;
            rx_q.push_back(dec_bits[8:1]);
            dec_cnt = -1;
         end else begin
            dec_cnt++;
         end
      end
      @(posedge clk);
      #1;
      repeat (int'(s_pop)) if (fifo.size() > 0) void'(fifo.pop_front());
      drive_fifo();
   endtask

   task automatic run_burst(input string tag, input int budget, output int busy_cnt);
      bit seen;
      int n;
      seen     = 1'b0;
      busy_cnt = 0;
      n        = 0;
      while (n < budget) begin
         cycle();
         n++;
         if (s_busy) begin
            seen = 1'b1;
            busy_cnt++;
         end else if (seen) begin
            break;
         end
      end
      check({tag, "_done"}, 64'(n >= budget), 64'd0);
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) check(tag, rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic clear_pops();
      pop_log.delete();
      pop_at.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         bc;
      int         bad;
      logic [9:0] seq;
      logic [63:0] exp_wave;

      rst      = 1'b1;
      can_pop  = '0;
      pop_data = '0;

      // 1: reset values and quiet idle line
      #1;
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_pop", pop, 0);
      check("rst_frames", frames_sent, 0);
      #20 rst = 1'b0;
      bad = 0;
      repeat (20) begin
         cycle();
         if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_pop !== 3'd0) bad++;
      end
      check("idle_quiet", bad, 0);

      // 2: three bytes in one burst
      clear_pops();
      push(8'h01); push(8'h02); push(8'h03);
      run_burst("b3", 400, bc);
      check("b3_busy_cycles", bc, 120);
      check("b3_npop", pop_log.size(), 1);
      if (pop_log.size() > 0) check("b3_pop", pop_log[0], 3);
      check("b3_frames", s_frames, 3);
      check_rx("b3_rx");

      // 3: pushes during a 2-byte burst wait for the next IDLE
      clear_pops();
      push(8'h11); push(8'h22);
      repeat (10) cycle();
      push(8'h06); push(8'h07); push(8'h08); push(8'h09);
      run_burst("b2", 400, bc);
      run_burst("b4", 400, bc);
      check("b24_npop", pop_log.size(), 2);
      if (pop_log.size() == 2) begin
         check("b24_pop0", pop_log[0], 2);
         check("b24_pop1", pop_log[1], 4);
         check("b24_gap", pop_at[1] - pop_at[0], 81);
      end
      check("b24_busy_cycles", bc, 160);
      check("b24_frames", s_frames, 9);
      check_rx("b24_rx");

      // 4: single byte 0xA5, exact waveform
      clear_pops();
      push(8'hA5);
      cycle();
      check("a5_pop", s_pop, 1);
      repeat (40) cycle();
      seq = 10'b0101001011;
      exp_wave = '0;
      for (int b = 0; b < 10; b++) begin
         for (int r = 0; r < DIV; r++) exp_wave = {exp_wave[62:0], seq[9-b]};
      end
      check("a5_wave", wave[39:0], exp_wave);
      cycle();
      check("a5_busy_end", s_busy, 0);
      check("a5_frames", s_frames, 10);
      check_rx("a5_rx");

      // 5: async reset during the second byte of a 3-byte burst
      clear_pops();
      push(8'h3C); push(8'hC3); push(8'h5A);
      cycle();
      check("r_pop", s_pop, 3);
      repeat (50) cycle();
      check("r_busy_pre", s_busy, 1);
      check("r_frames_pre", s_frames, 11);
      check("r_rx_pre", rx_q.size(), 1);
      if (rx_q.size() > 0) check("r_rx_byte0", rx_q[0], 8'h3C);
      #2 rst = 1'b1;
      #1;
      check("r_tx_async", tx, 1);
      check("r_busy_async", busy, 0);
      check("r_frames_async", frames_sent, 0);
      dec_cnt = -1;
      rx_q.delete();
      exp_q.delete();
      #13 rst = 1'b0;
      clear_pops();
      bad = 0;
      repeat (30) begin
         cycle();
         if (s_tx !== 1'b1 || s_busy !== 1'b0) bad++;
      end
      check("r_quiet_after", bad, 0);
      check("r_no_pop", pop_log.size(), 0);

      // 6: 4 + 4 bytes, second group waiting when IDLE is entered
      clear_pops();
      push(8'h40); push(8'h41); push(8'h42); push(8'h43);
      cycle();
      repeat (3) cycle();
      push(8'h50); push(8'h51); push(8'h52); push(8'h53);
      run_burst("q4a", 400, bc);
      run_burst("q4b", 400, bc);
      check("q44_npop", pop_log.size(), 2);
      if (pop_log.size() == 2) begin
         check("q44_pop0", pop_log[0], 4);
         check("q44_pop1", pop_log[1], 4);
         check("q44_gap", pop_at[1] - pop_at[0], 161);
      end
      check("q44_frames", s_frames, 8);
      check_rx("q44_rx");

      // 7: can_pop above NO is clamped
      clear_pops();
      push(8'h71); push(8'h72); push(8'h73); push(8'h74); push(8'h75);
      run_burst("c4", 400, bc);
      run_burst("c1", 400, bc);
      check("clamp_npop", pop_log.size(), 2);
      if (pop_log.size() == 2) begin
         check("clamp_pop0", pop_log[0], 4);
         check("clamp_pop1", pop_log[1], 1);
      end
      check("clamp_frames", s_frames, 13);
      check_rx("clamp_rx");

      check("pop_while_busy", viol, 0);
      check("frame_err", frame_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
